multicycle_control: RTL and testbench

- Multicycle sequencing FSM for the MIPS datapath. Replaces the single-cycle decode path with one shared ALU and one unified memory.
- Steps each instruction through fetch / decode / execute / memory / writeback.
- Drives every datapath mux select and write enable, and resolves conditional branches from the ALU Zero flag.
- Stalls on a memory ready handshake.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS datapath.
// The master side is the sequencer: it reads the opcode, Zero and memory-ready, and drives every select/enable.
interface multicycle_control_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         i_op;
  logic               i_zero;
  logic               i_mem_ready;
  logic               o_iord;
  logic               o_mem_read;
  logic               o_mem_write;
  logic               o_ir_write;
  logic               o_reg_dst;
  logic               o_mem_to_reg;
  logic               o_reg_write;
  logic               o_alu_src_a;
  logic [1:0]         o_alu_src_b;
  logic [ALUOP_W-1:0] o_alu_op;
  logic [1:0]         o_pc_src;
  logic               o_pc_write;
  logic               o_illegal_op;
  logic [3:0]         o_state;

  modport master (
    input  i_op, i_zero, i_mem_ready,
    output o_iord, o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_pc_write,
           o_illegal_op, o_state
  );

  modport slave (
    output i_op, i_zero, i_mem_ready,
    input  o_iord, o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_pc_write,
           o_illegal_op, o_state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: fetch/decode/execute/memory/writeback with one shared ALU and one memory.
// Memory handshake: a request (mem_read/mem_write) is held until i_mem_ready is 1 in the same cycle; that cycle completes it.
module multicycle_control #(
  parameter int ALUOP_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(7);

  // fetch/branch/jump mark the states whose PC/IR enables are qualified combinationally.
  typedef struct packed {
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               fetch;
    logic               branch;
    logic               jump;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.fetch     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.jump   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_legal;
  logic   branch_taken;

  always_comb begin
    case (bus.i_op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: op_legal = 1'b1;
      default:                                                  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.i_op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_R:            state_d = S_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.i_op == OP_LW) ? S_MEMRD :
                          (bus.i_op == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:  state_d = bus.i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs are registered alongside the state so they change only on the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, 6'd0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, bus.i_op);
    end
  end

  assign branch_taken = ((bus.i_op == OP_BEQ) &  bus.i_zero) |
                        ((bus.i_op == OP_BNE) & ~bus.i_zero);

  // Every output is gated by rst so an abort blocks all writes in the reset cycle itself.
  assign bus.o_iord        = rst & ctrl_q.iord;
  assign bus.o_mem_read    = rst & ctrl_q.mem_read;
  assign bus.o_mem_write   = rst & ctrl_q.mem_write;
  assign bus.o_ir_write    = rst & ctrl_q.fetch & bus.i_mem_ready;
  assign bus.o_reg_dst     = rst & ctrl_q.reg_dst;
  assign bus.o_mem_to_reg  = rst & ctrl_q.mem_to_reg;
  assign bus.o_reg_write   = rst & ctrl_q.reg_write;
  assign bus.o_alu_src_a   = rst & ctrl_q.alu_src_a;
  assign bus.o_alu_src_b   = rst ? ctrl_q.alu_src_b : 2'b00;
  assign bus.o_alu_op      = rst ? ctrl_q.alu_op : '0;
  assign bus.o_pc_src      = rst ? ctrl_q.pc_src : 2'b00;
  assign bus.o_pc_write    = rst & ((ctrl_q.fetch & bus.i_mem_ready) | ctrl_q.jump |
                                    (ctrl_q.branch & branch_taken));
  assign bus.o_illegal_op  = rst & (state_q == S_DECODE) & ~op_legal;
  assign bus.o_state       = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's stimulus pushes its expected output vector,
// and a negedge monitor pops and compares, plus checks the enable invariants every cycle.
module tb_multicycle_control;
  localparam int ALUOP_W = 3;
  localparam int VW = 21;
  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst;

  multicycle_control_if #(.ALUOP_W(ALUOP_W)) bus ();

  multicycle_control #(.ALUOP_W(ALUOP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_cmp;
  int    n_fail;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Field order: state, illegal, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  // reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_write.
  function automatic vec_t v(input logic [3:0] st, input logic ill, input logic iord,
                             input logic mr, input logic mw, input logic irw, input logic rd,
                             input logic m2r, input logic rw, input logic asa,
                             input logic [1:0] asb, input logic [2:0] aop,
                             input logic [1:0] psrc, input logic pcw);
    return {st, ill, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pcw};
  endfunction

  function automatic vec_t actual();
    return {bus.o_state, bus.o_illegal_op, bus.o_iord, bus.o_mem_read, bus.o_mem_write,
            bus.o_ir_write, bus.o_reg_dst, bus.o_mem_to_reg, bus.o_reg_write,
            bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op, bus.o_pc_src, bus.o_pc_write};
  endfunction

  // Hand-written expected vectors for each state
  function automatic vec_t e_zero();                 return '0; endfunction
  function automatic vec_t e_fetch(input logic r);   return v(4'd0, 0, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, r); endfunction
  function automatic vec_t e_decode(input logic il); return v(4'd1, il, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_memadr();               return v(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_memrd();                return v(4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_memwb();                return v(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_memwr();                return v(4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_exec();                 return v(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0); endfunction
  function automatic vec_t e_rwb();                  return v(4'd7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_branch(input logic t);  return v(4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, t); endfunction
  function automatic vec_t e_iexec(input logic [2:0] aop); return v(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, aop, 2'b00, 0); endfunction
  function automatic vec_t e_iwb();                  return v(4'd10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0); endfunction
  function automatic vec_t e_jump();                 return v(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1); endfunction

  // driver: one clock cycle of stimulus plus its expected response
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                      input vec_t e, input string nm);
    @(posedge clk);
    #1;
    rst             = r;
    bus.i_op        = op;
    bus.i_zero      = z;
    bus.i_mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t  e;
      vec_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
      end
      n_cmp++;
      if ((bus.o_mem_read & bus.o_mem_write) !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_mem_rw %s: got read=%b write=%b required not both 1", nm, bus.o_mem_read, bus.o_mem_write);
      end
      n_cmp++;
      if ((bus.o_reg_write & bus.o_pc_write) !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_reg_pc %s: got reg_write=%b pc_write=%b required not both 1", nm, bus.o_reg_write, bus.o_pc_write);
      end
    end
  end

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    rst             = 1'b0;
    bus.i_op        = 6'd0;
    bus.i_zero      = 1'b0;
    bus.i_mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) step(0, OP_R, 0, 1, e_zero(), "reset_hold");

    // R-type: 0,1,6,7
    step(1, OP_R, 0, 1, e_fetch(1), "r_fetch");
    step(1, OP_R, 0, 1, e_decode(0), "r_decode");
    step(1, OP_R, 0, 1, e_exec(), "r_exec");
    step(1, OP_R, 0, 1, e_rwb(), "r_rwb");

    // lw with two wait cycles in MEMRD: 7 cycles
    step(1, OP_LW, 0, 1, e_fetch(1), "lw_fetch");
    step(1, OP_LW, 0, 1, e_decode(0), "lw_decode");
    step(1, OP_LW, 0, 1, e_memadr(), "lw_memadr");
    step(1, OP_LW, 0, 0, e_memrd(), "lw_memrd_w0");
    step(1, OP_LW, 0, 0, e_memrd(), "lw_memrd_w1");
    step(1, OP_LW, 0, 1, e_memrd(), "lw_memrd_rdy");
    step(1, OP_LW, 0, 1, e_memwb(), "lw_memwb");

    // branches
    step(1, OP_BEQ, 1, 1, e_fetch(1), "beq_fetch");
    step(1, OP_BEQ, 1, 1, e_decode(0), "beq_decode");
    step(1, OP_BEQ, 1, 1, e_branch(1), "beq_z1_taken");
    step(1, OP_BNE, 1, 1, e_fetch(1), "bne_fetch");
    step(1, OP_BNE, 1, 1, e_decode(0), "bne_decode");
    step(1, OP_BNE, 1, 1, e_branch(0), "bne_z1_not_taken");
    step(1, OP_BEQ, 0, 1, e_fetch(1), "beq2_fetch");
    step(1, OP_BEQ, 0, 1, e_decode(0), "beq2_decode");
    step(1, OP_BEQ, 0, 1, e_branch(0), "beq_z0_not_taken");
    step(1, OP_BNE, 0, 1, e_fetch(1), "bne2_fetch");
    step(1, OP_BNE, 0, 1, e_decode(0), "bne2_decode");
    step(1, OP_BNE, 0, 1, e_branch(1), "bne_z0_taken");

    // illegal opcode, then jump
    step(1, OP_BAD, 0, 1, e_fetch(1), "bad_fetch");
    step(1, OP_BAD, 0, 1, e_decode(1), "bad_decode_illegal");
    step(1, OP_J, 0, 1, e_fetch(1), "j_fetch");
    step(1, OP_J, 0, 1, e_decode(0), "j_decode");
    step(1, OP_J, 0, 1, e_jump(), "j_jump");

    // addi with one fetch wait, then ori
    step(1, OP_ADDI, 0, 0, e_fetch(0), "addi_fetch_wait");
    step(1, OP_ADDI, 0, 1, e_fetch(1), "addi_fetch");
    step(1, OP_ADDI, 0, 1, e_decode(0), "addi_decode");
    step(1, OP_ADDI, 0, 1, e_iexec(3'b000), "addi_iexec");
    step(1, OP_ADDI, 0, 1, e_iwb(), "addi_iwb");
    step(1, OP_ORI, 0, 1, e_fetch(1), "ori_fetch");
    step(1, OP_ORI, 0, 1, e_decode(0), "ori_decode");
    step(1, OP_ORI, 0, 1, e_iexec(3'b011), "ori_iexec");
    step(1, OP_ORI, 0, 1, e_iwb(), "ori_iwb");

    // sw completing normally
    step(1, OP_SW, 0, 1, e_fetch(1), "sw_fetch");
    step(1, OP_SW, 0, 1, e_decode(0), "sw_decode");
    step(1, OP_SW, 0, 1, e_memadr(), "sw_memadr");
    step(1, OP_SW, 0, 1, e_memwr(), "sw_memwr_rdy");

    // sw aborted by reset while waiting in MEMWR
    step(1, OP_SW, 0, 1, e_fetch(1), "sw2_fetch");
    step(1, OP_SW, 0, 1, e_decode(0), "sw2_decode");
    step(1, OP_SW, 0, 1, e_memadr(), "sw2_memadr");
    step(1, OP_SW, 0, 0, e_memwr(), "sw2_memwr_wait");
    step(0, OP_SW, 0, 0, e_zero(), "sw2_abort_reset");
    step(0, OP_SW, 0, 0, e_zero(), "sw2_reset_hold");
    step(1, OP_SW, 0, 1, e_fetch(1), "post_abort_fetch");
    step(1, OP_SW, 0, 1, e_decode(0), "post_abort_decode");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
